// File: rtl/multiplier_arbiter.sv
// Round-robin sequencer sharing one external Width x Width unsigned multiplier
// among NumReq requesters over valid/ready request and response handshakes.
module multiplier_arbiter #(
  parameter int Width      = 8,
  parameter int NumReq     = 4,
  parameter int MulLatency = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic [NumReq-1:0][Width-1:0]  req_in1_i,
  input  logic [NumReq-1:0][Width-1:0]  req_in2_i,
  output logic [NumReq-1:0]             rsp_valid_o,
  input  logic [NumReq-1:0]             rsp_ready_i,
  output logic [2*Width-1:0]            rsp_product_o,
  output logic [Width-1:0]              mul_in1_o,
  output logic [Width-1:0]              mul_in2_o,
  input  logic [2*Width-1:0]            mul_out_i,
  output logic                          busy_o
);

  localparam int          GrantW  = $clog2(NumReq);
  localparam int unsigned NumReqU = NumReq;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state, state_next;
  logic [Width-1:0]    op1, op2;
  logic [2*Width-1:0]  prod;
  logic [3:0]          cnt;
  logic [GrantW-1:0]   grant, last_grant, winner;
  logic                found;

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin : rr_pick
    int unsigned       idx;
    logic [GrantW-1:0] cand;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    cand   = '0;
    for (int unsigned i = 1; i <= NumReqU; i++) begin
      idx  = (32'(last_grant) + i) % NumReqU;
      cand = GrantW'(idx);
      if (!found && req_valid_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin : fsm_next
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = WAIT;
      WAIT:    if (cnt == 4'd1) state_next = RESP;
      RESP:    if (rsp_ready_i[grant]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Ready is gated by reset so outputs read zero while reset is held.
  always_comb begin : handshake_out
    req_ready_o = '0;
    rsp_valid_o = '0;
    if (state == IDLE && found && !rst_i) req_ready_o[winner] = 1'b1;
    if (state == RESP) rsp_valid_o[grant] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      op1        <= '0;
      op2        <= '0;
      prod       <= '0;
      cnt        <= '0;
      grant      <= '0;
      last_grant <= GrantW'(NumReq - 1);
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (found) begin
            op1        <= req_in1_i[winner];
            op2        <= req_in2_i[winner];
            grant      <= winner;
            last_grant <= winner;
            cnt        <= 4'(MulLatency);
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) prod <= mul_out_i;
        end
        default: ;
      endcase
    end
  end

  assign mul_in1_o     = op1;
  assign mul_in2_o     = op2;
  assign rsp_product_o = prod;
  assign busy_o        = (state != IDLE);

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Directed bench for multiplier_arbiter: one instance with a combinational core
// (MulLatency=1) and one with a two-register core (MulLatency=3).
module tb_multiplier_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A: MulLatency=1, combinational core
  logic [3:0]       a_valid, a_ready, a_rvalid, a_rready;
  logic [3:0][7:0]  a_in1, a_in2;
  logic [15:0]      a_prod, a_mout;
  logic [7:0]       a_m1, a_m2;
  logic             a_busy;

  // Instance B: MulLatency=3, registered core
  logic [3:0]       b_valid, b_ready, b_rvalid, b_rready;
  logic [3:0][7:0]  b_in1, b_in2;
  logic [15:0]      b_prod, b_mout, b_r1, b_r2;
  logic [7:0]       b_m1, b_m2;
  logic             b_busy;

  multiplier_arbiter #(.Width(8), .NumReq(4), .MulLatency(1)) u_a (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(a_valid), .req_ready_o(a_ready),
    .req_in1_i(a_in1), .req_in2_i(a_in2),
    .rsp_valid_o(a_rvalid), .rsp_ready_i(a_rready), .rsp_product_o(a_prod),
    .mul_in1_o(a_m1), .mul_in2_o(a_m2), .mul_out_i(a_mout),
    .busy_o(a_busy)
  );

  multiplier_arbiter #(.Width(8), .NumReq(4), .MulLatency(3)) u_b (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(b_valid), .req_ready_o(b_ready),
    .req_in1_i(b_in1), .req_in2_i(b_in2),
    .rsp_valid_o(b_rvalid), .rsp_ready_i(b_rready), .rsp_product_o(b_prod),
    .mul_in1_o(b_m1), .mul_in2_o(b_m2), .mul_out_i(b_mout),
    .busy_o(b_busy)
  );

  assign a_mout = 16'(a_m1) * 16'(a_m2);

  always_ff @(posedge clk) begin
    b_r1 <= 16'(b_m1) * 16'(b_m2);
    b_r2 <= b_r1;
  end
  assign b_mout = b_r2;

  logic [31:0] all4_rdy [4] = '{32'b0001, 32'b0010, 32'b0100, 32'b1000};
  logic [31:0] all4_p   [4] = '{20678, 9471, 0, 65025};
  logic [31:0] fair_rdy [7] = '{32'b0001, 32'b0100, 32'b0001, 32'b0100,
                                32'b0001, 32'b0010, 32'b0100};
  logic [31:0] fair_p   [7] = '{15, 200, 15, 200, 15, 256, 200};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_valid = '0; a_rready = '0; a_in1 = '0; a_in2 = '0;
    b_valid = '0; b_rready = '0; b_in1 = '0; b_in2 = '0;
    #2;
    chk("rst_a_ready",  32'(a_ready), 0);
    chk("rst_a_rvalid", 32'(a_rvalid), 0);
    chk("rst_a_prod",   32'(a_prod), 0);
    chk("rst_a_m1",     32'(a_m1), 0);
    chk("rst_a_m2",     32'(a_m2), 0);
    chk("rst_a_busy",   32'(a_busy), 0);
    chk("rst_b_busy",   32'(b_busy), 0);
    tick(); tick();
    rst = 1'b0;

    // Single request from requester 1: 2 x 7
    tick();
    a_valid = 4'b0010; a_in1[1] = 8'd2; a_in2[1] = 8'd7; a_rready = 4'b1111;
    #1;
    chk("t1_ready_T", 32'(a_ready), 32'b0010);
    chk("t1_busy_T",  32'(a_busy), 0);
    tick(); a_valid = '0; #1;
    chk("t1_m1_T1",     32'(a_m1), 2);
    chk("t1_m2_T1",     32'(a_m2), 7);
    chk("t1_busy_T1",   32'(a_busy), 1);
    chk("t1_rvalid_T1", 32'(a_rvalid), 0);
    tick(); #1;
    chk("t1_rvalid_T2", 32'(a_rvalid), 32'b0010);
    chk("t1_prod_T2",   32'(a_prod), 14);
    chk("t1_busy_T2",   32'(a_busy), 1);
    tick(); #1;
    chk("t1_busy_T3",   32'(a_busy), 0);
    chk("t1_rvalid_T3", 32'(a_rvalid), 0);

    // All four valid from reset, held; grants 0,1,2,3 every 3 cycles
    rst = 1'b1;
    a_in1[0] = 8'd211; a_in2[0] = 8'd98;
    a_in1[1] = 8'd123; a_in2[1] = 8'd77;
    a_in1[2] = 8'd0;   a_in2[2] = 8'd0;
    a_in1[3] = 8'd255; a_in2[3] = 8'd255;
    a_valid = 4'b1111;
    #1;
    chk("t2_ready_in_rst", 32'(a_ready), 0);
    tick();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t2_ready_%0d", k), 32'(a_ready), all4_rdy[k]);
      tick(); #1;
      chk($sformatf("t2_wait_ready_%0d", k), 32'(a_ready), 0);
      tick(); #1;
      chk($sformatf("t2_rvalid_%0d", k), 32'(a_rvalid), all4_rdy[k]);
      chk($sformatf("t2_prod_%0d", k),   32'(a_prod), all4_p[k]);
      tick();
    end
    a_valid = '0;
    #1;

    // Fairness: 0 and 2 continuous, 1 joins during the fifth transaction
    a_in1[0] = 8'd3;  a_in2[0] = 8'd5;
    a_in1[2] = 8'd10; a_in2[2] = 8'd20;
    a_in1[1] = 8'd16; a_in2[1] = 8'd16;
    a_valid = 4'b0101;
    #1;
    for (int s = 0; s < 7; s++) begin
      chk($sformatf("t3_ready_%0d", s), 32'(a_ready), fair_rdy[s]);
      tick();
      if (s == 4) a_valid[1] = 1'b1;
      if (s == 5) a_valid[1] = 1'b0;
      tick(); #1;
      chk($sformatf("t3_rvalid_%0d", s), 32'(a_rvalid), fair_rdy[s]);
      chk($sformatf("t3_prod_%0d", s),   32'(a_prod), fair_p[s]);
      tick();
    end
    a_valid = '0;
    #1;

    // Backpressure on requester 3; other requesters valid and their ready bits high
    a_in1[3] = 8'd255; a_in2[3] = 8'd255;
    a_valid = 4'b1111; a_rready = 4'b0111;
    #1;
    chk("t4_ready_T", 32'(a_ready), 32'b1000);
    tick(); a_valid = 4'b0111; #1;
    chk("t4_ready_wait", 32'(a_ready), 0);
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      chk($sformatf("t4_rvalid_%0d", i), 32'(a_rvalid), 32'b1000);
      chk($sformatf("t4_prod_%0d", i),   32'(a_prod), 65025);
      chk($sformatf("t4_ready_%0d", i),  32'(a_ready), 0);
    end
    tick(); a_rready = 4'b1111; #1;
    chk("t4_rvalid_last", 32'(a_rvalid), 32'b1000);
    chk("t4_prod_last",   32'(a_prod), 65025);
    tick(); #1;
    chk("t4_rvalid_after", 32'(a_rvalid), 0);
    chk("t4_ready_after",  32'(a_ready), 32'b0001);
    a_valid = '0;
    #1;

    // MulLatency=3 instance: 123 x 77
    b_rready = 4'b1111;
    tick();
    b_valid = 4'b0010; b_in1[1] = 8'd123; b_in2[1] = 8'd77;
    #1;
    chk("t5_ready_T", 32'(b_ready), 32'b0010);
    tick(); b_valid = '0; #1;
    chk("t5_m1_T1",     32'(b_m1), 123);
    chk("t5_busy_T1",   32'(b_busy), 1);
    chk("t5_rvalid_T1", 32'(b_rvalid), 0);
    tick(); #1;
    chk("t5_rvalid_T2", 32'(b_rvalid), 0);
    tick(); #1;
    chk("t5_rvalid_T3", 32'(b_rvalid), 0);
    tick(); #1;
    chk("t5_rvalid_T4", 32'(b_rvalid), 32'b0010);
    chk("t5_prod_T4",   32'(b_prod), 9471);
    tick(); #1;
    chk("t5_busy_T5",   32'(b_busy), 0);

    // Asynchronous reset during WAIT
    a_in1[2] = 8'd9; a_in2[2] = 8'd9;
    a_valid = 4'b0100; a_rready = 4'b1111;
    #1;
    chk("t6_ready_T", 32'(a_ready), 32'b0100);
    tick(); a_valid = '0; #1;
    chk("t6_busy_wait", 32'(a_busy), 1);
    chk("t6_m1_wait",   32'(a_m1), 9);
    rst = 1'b1;
    #1;
    chk("t6_rst_ready",  32'(a_ready), 0);
    chk("t6_rst_rvalid", 32'(a_rvalid), 0);
    chk("t6_rst_prod",   32'(a_prod), 0);
    chk("t6_rst_m1",     32'(a_m1), 0);
    chk("t6_rst_m2",     32'(a_m2), 0);
    chk("t6_rst_busy",   32'(a_busy), 0);
    tick(); tick();
    rst = 1'b0;
    tick(); #1;
    chk("t6_post_rvalid0", 32'(a_rvalid), 0);
    tick(); #1;
    chk("t6_post_rvalid1", 32'(a_rvalid), 0);
    chk("t6_post_busy",    32'(a_busy), 0);
    a_valid = 4'b1001;
    #1;
    chk("t6_first_grant", 32'(a_ready), 32'b0001);
    a_valid = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
